// File: rtl/uart_debug_loader_pkg.sv
// rtl/uart_debug_loader_pkg.sv - command codes, reply bytes and FSM states for the debug loader.
package uart_debug_loader_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_HALT = 8'h03;

  localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
  localparam logic [7:0] NAK_BYTE_DEF = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DECODE,
    ST_LEN,
    ST_CHKLEN,
    ST_BYTE,
    ST_ASSEMBLE,
    ST_WRITE,
    ST_REPLY,
    ST_START
  } state_e;

endpackage

// File: rtl/uart_debug_loader_byte_to_word_assembler.sv
// rtl/uart_debug_loader_byte_to_word_assembler.sv - little-endian byte-to-word shifter with byte index and word-complete flag.
module uart_debug_loader_byte_to_word_assembler
  import uart_debug_loader_pkg::*;
#(
  parameter int NB_INSTRUCTION = 32
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_shift,
  input  logic                      i_clear,
  input  logic [7:0]                i_byte,
  output logic [NB_INSTRUCTION-1:0] o_word,
  output logic                      o_full
);

  localparam int NB_BYTES = NB_INSTRUCTION / 8;
  localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  logic [IDX_W-1:0]          idx_q;
  logic [NB_INSTRUCTION-1:0] word_q;
  logic                      full_q;

  // New bytes enter at the top, so the first byte ends up in bits [7:0].
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q  <= '0;
      word_q <= '0;
      full_q <= 1'b0;
    end else if (i_clear) begin
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (i_shift) begin
      word_q <= (word_q >> 8) | (NB_INSTRUCTION'(i_byte) << (NB_INSTRUCTION - 8));
      if (idx_q == IDX_W'(NB_BYTES - 1)) begin
        full_q <= 1'b1;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign o_word = word_q;
  assign o_full = full_q;

endmodule

// File: rtl/uart_debug_loader.sv
// rtl/uart_debug_loader.sv - UART command responder: loads imem word by word, gates CPU enable, replies ACK/NAK.
module uart_debug_loader
  import uart_debug_loader_pkg::*;
#(
  parameter int                NB_INSTRUCTION  = 32,
  parameter int                IMEM_ADDR_WIDTH = 7,
  parameter int                NB_UART_DATA    = 8,
  parameter logic [7:0]        ACK_BYTE        = ACK_BYTE_DEF,
  parameter logic [7:0]        NAK_BYTE        = NAK_BYTE_DEF
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [NB_UART_DATA-1:0]    i_rx_data,
  input  logic                       i_rx_empty,
  output logic                       o_rd,
  input  logic                       i_tx_full,
  output logic                       o_wr,
  output logic [NB_UART_DATA-1:0]    o_wdata,
  output logic                       o_tx_start,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
  output logic                       o_cpu_en,
  output logic                       o_busy
);

  localparam int          WCW       = IMEM_ADDR_WIDTH + 1;
  localparam int unsigned MAX_WORDS = 2 ** IMEM_ADDR_WIDTH;

  state_e                   state_q;
  logic [NB_UART_DATA-1:0]  cmd_q;
  logic [NB_UART_DATA-1:0]  len_q;
  logic [NB_UART_DATA-1:0]  reply_q;
  logic [WCW-1:0]           word_cnt_q;
  logic                     fetch;
  logic                     asm_shift;
  logic                     asm_clear;
  logic                     asm_full;
  logic [NB_INSTRUCTION-1:0] asm_word;

  // A fetch state pops and captures in the same cycle; the next state never fetches.
  assign fetch     = (state_q == ST_IDLE || state_q == ST_LEN || state_q == ST_BYTE) && !i_rx_empty;
  assign o_rd      = fetch && !i_rst;
  assign asm_shift = (state_q == ST_BYTE) && !i_rx_empty;
  assign asm_clear = (state_q == ST_CHKLEN) || (state_q == ST_WRITE);
  assign o_busy    = (state_q != ST_IDLE);

  uart_debug_loader_byte_to_word_assembler #(
    .NB_INSTRUCTION(NB_INSTRUCTION)
  ) u_asm (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_shift(asm_shift),
    .i_clear(asm_clear),
    .i_byte (i_rx_data[7:0]),
    .o_word (asm_word),
    .o_full (asm_full)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      len_q        <= '0;
      reply_q      <= '0;
      word_cnt_q   <= '0;
      o_wr         <= 1'b0;
      o_wdata      <= '0;
      o_tx_start   <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_cpu_en     <= 1'b0;
    end else begin
      o_wr       <= 1'b0;
      o_tx_start <= 1'b0;
      o_imem_we  <= 1'b0;
      case (state_q)
        ST_IDLE: if (!i_rx_empty) begin
          cmd_q   <= i_rx_data;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          state_q <= ST_REPLY;
          reply_q <= ACK_BYTE;
          if (cmd_q == CMD_LOAD) begin
            o_cpu_en <= 1'b0;
            state_q  <= ST_LEN;
          end else if (cmd_q == CMD_RUN) begin
            o_cpu_en <= 1'b1;
          end else if (cmd_q == CMD_HALT) begin
            o_cpu_en <= 1'b0;
          end else begin
            reply_q <= NAK_BYTE;
          end
        end
        ST_LEN: if (!i_rx_empty) begin
          len_q   <= i_rx_data;
          state_q <= ST_CHKLEN;
        end
        ST_CHKLEN: begin
          word_cnt_q <= '0;
          if (len_q == '0 || 32'(len_q) > MAX_WORDS) begin
            reply_q <= NAK_BYTE;
            state_q <= ST_REPLY;
          end else begin
            state_q <= ST_BYTE;
          end
        end
        ST_BYTE: if (!i_rx_empty) state_q <= ST_ASSEMBLE;
        ST_ASSEMBLE: begin
          if (asm_full) begin
            o_imem_we    <= 1'b1;
            o_imem_addr  <= word_cnt_q[IMEM_ADDR_WIDTH-1:0];
            o_imem_wdata <= asm_word;
            state_q      <= ST_WRITE;
          end else begin
            state_q <= ST_BYTE;
          end
        end
        ST_WRITE: begin
          word_cnt_q <= word_cnt_q + WCW'(1);
          if (32'(word_cnt_q) + 32'd1 == 32'(len_q)) begin
            reply_q <= ACK_BYTE;
            state_q <= ST_REPLY;
          end else begin
            state_q <= ST_BYTE;
          end
        end
        ST_REPLY: if (!i_tx_full) begin
          o_wr    <= 1'b1;
          o_wdata <= reply_q;
          state_q <= ST_START;
        end
        ST_START: begin
          o_tx_start <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
